voice_allocator: RTL and testbench
==================================

// Module: voice_allocator
// PURPOSE
//  Polyphonic voice scheduler for the keyboard synth. It accepts a stream of note-on/note-off
//  events and assigns each note to one of NUM_VOICES sine-generator voice slots (freq_lut ->
//  sine_generator chains). When all slots are busy it steals the oldest voice. Sits between the
//  key/switch event source and the per-voice tone datapath.
// PARAMETERS
//  NUM_VOICES  4  voice slots managed (2..16)
//  AGE_W       4  width of per-voice age counter (saturating)
// PORTS
//  clk_in            in   1             100MHz system clock
//  rst_in            in   1             reset, asynchronous, active-low
//  ev_valid_in       in   1             event valid
//  ev_ready_out      out  1             allocator can accept an event
//  ev_on_in          in   1             1 = note-on, 0 = note-off
//  ev_note_in        in   7             note index 0..127
//  sustain_in        in   1             sustain pedal (used only with VOICE_SUSTAIN_EN)
//  voice_active_out  out  NUM_VOICES    per-voice gate; drives the per-voice audio enable
//  voice_note_out    out  NUM_VOICES*7  per-voice note index, packed; voice i = [7i+6:7i]
//  voice_retrig_out  out  NUM_VOICES    1-cycle pulse: voice i (re)started; resets the phase
//  voice_steal_out   out  1             1-cycle pulse: the last note-on stole an active voice
// BEHAVIOUR
//  - Reset (rst_in=0, async): FSM=IDLE; all voice_active/note/age/retrig = 0; steal = 0;
//    ev_ready_out = 1. Reset asserted mid-scan aborts the event; the event is lost.
//  - Handshake: an event is accepted on an edge where ev_valid_in & ev_ready_out. The
//    ev_ready_out signal is 1 only in IDLE. Inputs are latched on acceptance.
//  - FSM IDLE -> SCAN (NUM_VOICES cycles, one voice per cycle, index 0 upward) -> COMMIT
//    -> IDLE.
//    - SCAN records three results: the first active voice whose note equals the event
//      note (match); the first inactive voice (free); and the active voice with the
//      largest age (oldest), with ties going to the lowest index.
//    - COMMIT updates the voice registers. Outputs are valid after the COMMIT edge,
//      which is NUM_VOICES+1 edges after acceptance. ev_ready_out is 1 again on the
//      same edge.
//  - Note-on:
//    - match -> retrigger that voice; age=0.
//    - else free -> assign; note=ev_note; active=1; age=0.
//    - else steal oldest -> note=ev_note; age=0; voice_steal_out pulses.
//    - On every path the target voice_retrig_out bit pulses for 1 cycle after COMMIT.
//    - On every accepted note-on, all other active voices' ages +1, saturating at
//      2^AGE_W-1.
//  - Note-off:
//    - match -> active=0. The note and age are held, and there is no pulse.
//    - no match -> the event is dropped silently, with the same latency.
//  - Note 0 is a legal note. Voices are distinguished by voice_active_out, never by
//    note==0.
//  - At most one voice matches, because the allocator never assigns a held note twice.
//  - ev_valid_in may stay high back-to-back; it is serviced one event per NUM_VOICES+2 cycles.
// CONFIGURATION
//  VOICE_SUSTAIN_EN defined:
//    - A note-off that matches while sustain_in=1 sets the voice's sustained flag
//      instead of clearing active.
//    - When sustain_in falls (1->0, sampled in clk_in), every sustained voice is freed
//      on the next IDLE cycle. This takes 1 cycle; ev_ready_out is 0 during it.
//    - A note-on that matches a sustained voice clears the flag and retriggers.
//  VOICE_SUSTAIN_EN undefined:
//    - sustain_in is ignored and note-offs always free voices.
//    - No sustained flags exist.
// STRUCTURE
//  - keyboard_pkg: NOTE_W=7; typedef note_t; typedef struct voice_t {active, sustained,
//    note, age}; typedef enum alloc_state_t {IDLE, SCAN, COMMIT, FLUSH}.
//  - Sub-module voice_scan: a per-cycle comparator plus running match/free/oldest
//    registers, reset at scan start.
//  - Voice state array and FSM live in voice_allocator.
// TESTING (NUM_VOICES=4, AGE_W=4)
//  - Reset: hold rst_in=0 mid-SCAN, then release.
//    -> active=0000, all notes=0, ev_ready_out=1, no pulses, FSM=IDLE.
//  - Note-on 60, 64, 67, each accepted when ready:
//    -> voices 0, 1, 2 active with notes 60/64/67.
//    -> each retrig bit pulses 5 edges after acceptance.
//    -> ev_ready_out is low for exactly 5 cycles per event.
//  - Fill with 60, 64, 67, 71, then note-on 72:
//    -> voice 0 gets note 72, steal pulses, voice_retrig=0001.
//    -> ages for voices 1..3 are 3, 2, 1.
//  - Note-off 64 -> voice 1 inactive; next note-on 50 -> voice 1 (first free), not a steal.
//    Note-off 99 (not held) -> no change.
//  - Note-on 64 while held in voice 1 -> voice 1 retrig pulse, no other voice changes,
//    steal=0.
//  - VOICE_SUSTAIN_EN:
//    - sustain_in=1, note-off 60 -> voice 0 stays active.
//    - sustain_in=0 -> voice 0 inactive within 2 cycles.
//    - Without the macro, the same stimulus frees voice 0 at COMMIT.

Source files
------------

// File: rtl/voice_allocator_pkg.sv
// -----------------------------------------------------------------------------
// keyboard_pkg
// Shared types for the keyboard synth voice allocator: note index type, the
// per-voice state record and the allocator FSM state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package keyboard_pkg;

    localparam int NOTE_W    = 7;
    // Storage width of the age field; the allocator saturates at 2^AGE_W-1,
    // so AGE_W may be anything up to this width.
    localparam int AGE_MAX_W = 16;

    typedef logic [NOTE_W-1:0]    note_t;
    typedef logic [AGE_MAX_W-1:0] age_t;

    typedef struct packed {
        logic  active;
        logic  sustained;
        note_t note;
        age_t  age;
    } voice_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        COMMIT,
        FLUSH
    } alloc_state_t;

endpackage

// File: rtl/voice_allocator_if.sv
// -----------------------------------------------------------------------------
// voice_allocator_if
// Note event handshake between the key/switch event source (master) and the
// voice allocator (slave).
//   ev_valid_in   master -> slave  event valid
//   ev_ready_out  slave  -> master allocator can accept an event
//   ev_on_in      master -> slave  1 = note-on, 0 = note-off
//   ev_note_in    master -> slave  note index 0..127
// -----------------------------------------------------------------------------
interface voice_allocator_if
    import keyboard_pkg::*;
();
    logic  ev_valid_in;
    logic  ev_ready_out;
    logic  ev_on_in;
    note_t ev_note_in;

    modport master (
        output ev_valid_in,
        output ev_on_in,
        output ev_note_in,
        input  ev_ready_out
    );

    modport slave (
        input  ev_valid_in,
        input  ev_on_in,
        input  ev_note_in,
        output ev_ready_out
    );
endinterface

// File: rtl/voice_scan.sv
// -----------------------------------------------------------------------------
// voice_scan
// Walks the voice slots one per cycle and keeps running results:
//   match  - first active voice holding the event note
//   free   - first inactive voice
//   oldest - active voice with the largest age, ties to the lowest index
// Ports:
//   clk_in, rst_in       clock, async active-low reset
//   start                clears the running results (new event accepted)
//   step                 examine the voice presented on idx/active/note/age
//   ev_note              note being searched for
//   match_found/idx, free_found/idx, oldest_idx   scan results
// -----------------------------------------------------------------------------
module voice_scan
    import keyboard_pkg::*;
#(
    parameter  int NUM_VOICES = 4,
    localparam int IDX_W      = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start,
    input  logic             step,
    input  logic [IDX_W-1:0] idx,
    input  logic             active,
    input  note_t            note,
    input  age_t             age,
    input  note_t            ev_note,
    output logic             match_found,
    output logic [IDX_W-1:0] match_idx,
    output logic             free_found,
    output logic [IDX_W-1:0] free_idx,
    output logic [IDX_W-1:0] oldest_idx
);
    logic oldest_found;
    age_t best_age;

    // Strict greater-than on age keeps the earliest (lowest index) voice on ties.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            match_found  <= 1'b0;
            match_idx    <= '0;
            free_found   <= 1'b0;
            free_idx     <= '0;
            oldest_found <= 1'b0;
            oldest_idx   <= '0;
            best_age     <= '0;
        end else if (start) begin
            match_found  <= 1'b0;
            match_idx    <= '0;
            free_found   <= 1'b0;
            free_idx     <= '0;
            oldest_found <= 1'b0;
            oldest_idx   <= '0;
            best_age     <= '0;
        end else if (step) begin
            if (active && (note == ev_note) && !match_found) begin
                match_found <= 1'b1;
                match_idx   <= idx;
            end
            if (!active && !free_found) begin
                free_found <= 1'b1;
                free_idx   <= idx;
            end
            if (active && (!oldest_found || (age > best_age))) begin
                oldest_found <= 1'b1;
                oldest_idx   <= idx;
                best_age     <= age;
            end
        end
    end
endmodule

// File: rtl/voice_allocator.sv
// -----------------------------------------------------------------------------
// voice_allocator
// Polyphonic voice scheduler: assigns note-on events to NUM_VOICES voice
// slots, retriggers held notes, steals the oldest voice when all are busy,
// and frees voices on note-off.
// Ports:
//   clk_in            system clock
//   rst_in            asynchronous active-low reset
//   ev                event handshake (voice_allocator_if.slave)
//   sustain_in        sustain pedal (only with VOICE_SUSTAIN_EN)
//   voice_active_out  per-voice gate
//   voice_note_out    per-voice note, voice i at [7i+6:7i]
//   voice_retrig_out  1-cycle pulse per (re)started voice
//   voice_steal_out   1-cycle pulse when a note-on stole an active voice
// Build option: define VOICE_SUSTAIN_EN to enable sustain pedal handling.
// -----------------------------------------------------------------------------
module voice_allocator
    import keyboard_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int AGE_W      = 4
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    voice_allocator_if.slave             ev,
    input  logic                         sustain_in,
    output logic [NUM_VOICES-1:0]        voice_active_out,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note_out,
    output logic [NUM_VOICES-1:0]        voice_retrig_out,
    output logic                         voice_steal_out
);
    localparam int               IDX_W    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
    localparam age_t             AGE_MAX  = age_t'((1 << AGE_W) - 1);

    alloc_state_t          state, next_state;
    voice_t                voices [NUM_VOICES];
    logic [IDX_W-1:0]      scan_idx, match_idx, free_idx, oldest_idx, target;
    logic                  match_found, free_found;
    logic                  ev_on_q;
    note_t                 ev_note_q;
    logic                  ready, scan_start, scan_step, flush_req;
    logic [NUM_VOICES-1:0] retrig_q;
    logic                  steal_q;

    voice_scan #(.NUM_VOICES(NUM_VOICES)) u_scan (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .start       (scan_start),
        .step        (scan_step),
        .idx         (scan_idx),
        .active      (voices[scan_idx].active),
        .note        (voices[scan_idx].note),
        .age         (voices[scan_idx].age),
        .ev_note     (ev_note_q),
        .match_found (match_found),
        .match_idx   (match_idx),
        .free_found  (free_found),
        .free_idx    (free_idx),
        .oldest_idx  (oldest_idx)
    );

    // A held note is reused first, then a free slot, otherwise the oldest voice.
    assign target = match_found ? match_idx : (free_found ? free_idx : oldest_idx);

`ifdef VOICE_SUSTAIN_EN
    logic sustain_d, flush_pending, ev_sustain_q, sustain_fall;

    assign sustain_fall = sustain_d & ~sustain_in;
    assign flush_req    = sustain_fall | flush_pending;

    // A pedal release seen while an event is in flight is remembered until the
    // FSM can spend a cycle in FLUSH.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sustain_d     <= 1'b0;
            flush_pending <= 1'b0;
            ev_sustain_q  <= 1'b0;
        end else begin
            sustain_d     <= sustain_in;
            flush_pending <= flush_req & (next_state != FLUSH);
            if (scan_start) begin
                ev_sustain_q <= sustain_in;
            end
        end
    end
`else
    logic                  unused_sustain_in;
    logic [NUM_VOICES-1:0] unused_sustained;

    assign flush_req         = 1'b0;
    assign unused_sustain_in = sustain_in;

    always_comb begin
        unused_sustained = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            unused_sustained[i] = voices[i].sustained;
        end
    end
`endif

    // Event acceptance wins over a flush in IDLE; a flush requested meanwhile is
    // taken straight after COMMIT so back-to-back events cannot starve it.
    always_comb begin
        next_state = state;
        ready      = 1'b0;
        scan_start = 1'b0;
        scan_step  = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (ev.ev_valid_in) begin
                    next_state = SCAN;
                    scan_start = 1'b1;
                end else if (flush_req) begin
                    next_state = FLUSH;
                end
            end
            SCAN: begin
                scan_step = 1'b1;
                if (scan_idx == LAST_IDX) begin
                    next_state = COMMIT;
                end
            end
            COMMIT:  next_state = flush_req ? FLUSH : IDLE;
            FLUSH:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register, event latch, scan pointer and voice register updates.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state     <= IDLE;
            scan_idx  <= '0;
            ev_on_q   <= 1'b0;
            ev_note_q <= '0;
            retrig_q  <= '0;
            steal_q   <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                voices[i] <= '0;
            end
        end else begin
            state    <= next_state;
            retrig_q <= '0;
            steal_q  <= 1'b0;
            if (scan_start) begin
                scan_idx  <= '0;
                ev_on_q   <= ev.ev_on_in;
                ev_note_q <= ev.ev_note_in;
            end else if (scan_step) begin
                scan_idx <= scan_idx + 1'b1;
            end

            if (state == COMMIT) begin
                if (ev_on_q) begin
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (voices[i].active && (IDX_W'(i) != target)) begin
                            voices[i].age <= (voices[i].age >= AGE_MAX) ? AGE_MAX
                                                                        : voices[i].age + 1'b1;
                        end
                    end
                    voices[target].active    <= 1'b1;
                    voices[target].sustained <= 1'b0;
                    voices[target].note      <= ev_note_q;
                    voices[target].age       <= '0;
                    retrig_q <= {{(NUM_VOICES-1){1'b0}}, 1'b1} << target;
                    steal_q  <= ~match_found & ~free_found;
                end else if (match_found) begin
`ifdef VOICE_SUSTAIN_EN
                    if (ev_sustain_q) begin
                        voices[match_idx].sustained <= 1'b1;
                    end else begin
                        voices[match_idx].active <= 1'b0;
                    end
`else
                    voices[match_idx].active <= 1'b0;
`endif
                end
            end

`ifdef VOICE_SUSTAIN_EN
            if (state == FLUSH) begin
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (voices[i].sustained) begin
                        voices[i].active    <= 1'b0;
                        voices[i].sustained <= 1'b0;
                    end
                end
            end
`endif
        end
    end

    // Flatten the voice array onto the output buses.
    always_comb begin
        voice_active_out = '0;
        voice_note_out   = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            voice_active_out[i]              = voices[i].active;
            voice_note_out[NOTE_W*i +: NOTE_W] = voices[i].note;
        end
    end

    assign ev.ev_ready_out   = ready;
    assign voice_retrig_out  = retrig_q;
    assign voice_steal_out   = steal_q;
endmodule

// File: tb/tb_voice_allocator.sv
// -----------------------------------------------------------------------------
// tb_voice_allocator
// Self-checking bench for voice_allocator (NUM_VOICES=4, AGE_W=4). A list-based
// model of the voice table predicts the target voice, steal flag and the
// resulting gates/notes for every event.
// -----------------------------------------------------------------------------
module tb_voice_allocator;
    localparam int NV      = 4;
    localparam int AGE_MAX = 15;

    logic        clk;
    logic        rst_n;
    logic        sustain;
    logic [3:0]  active;
    logic [27:0] notes;
    logic [3:0]  retrig;
    logic        steal;

    voice_allocator_if ev_bus ();

    voice_allocator #(.NUM_VOICES(NV), .AGE_W(4)) dut (
        .clk_in           (clk),
        .rst_in           (rst_n),
        .ev               (ev_bus),
        .sustain_in       (sustain),
        .voice_active_out (active),
        .voice_note_out   (notes),
        .voice_retrig_out (retrig),
        .voice_steal_out  (steal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference voice table
    bit   m_active [NV];
    bit   m_sus    [NV];
    int   m_note   [NV];
    int   m_age    [NV];
    logic [3:0] exp_retrig;
    logic       exp_steal;
    logic [3:0] obs_retrig;
    logic       obs_steal;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic void modelReset();
        for (int i = 0; i < NV; i++) begin
            m_active[i] = 0;
            m_sus[i]    = 0;
            m_note[i]   = 0;
            m_age[i]    = 0;
        end
    endfunction

    function automatic logic [3:0] modelActive();
        logic [3:0] v = '0;
        for (int i = 0; i < NV; i++) v[i] = m_active[i];
        return v;
    endfunction

    function automatic logic [27:0] modelNotes();
        logic [27:0] v = '0;
        for (int i = 0; i < NV; i++) v[7*i +: 7] = 7'(m_note[i]);
        return v;
    endfunction

    // Note-on: reuse held note, else first free, else oldest (lowest index on
    // ties); every other sounding voice ages by one, saturating.
    function automatic void modelEvent(input bit on, input int note, input bit sus);
        int match = -1;
        int free = -1;
        int oldest = -1;
        int target;
        for (int i = 0; i < NV; i++) begin
            if (m_active[i] && m_note[i] == note && match < 0) match = i;
            if (!m_active[i] && free < 0) free = i;
            if (m_active[i] && (oldest < 0 || m_age[i] > m_age[oldest])) oldest = i;
        end
        exp_retrig = '0;
        exp_steal  = 1'b0;
        if (on) begin
            target    = (match >= 0) ? match : ((free >= 0) ? free : oldest);
            exp_steal = (match < 0) && (free < 0);
            for (int i = 0; i < NV; i++) begin
                if (m_active[i] && i != target)
                    m_age[i] = (m_age[i] < AGE_MAX) ? m_age[i] + 1 : AGE_MAX;
            end
            m_active[target]   = 1;
            m_sus[target]      = 0;
            m_note[target]     = note;
            m_age[target]      = 0;
            exp_retrig[target] = 1'b1;
        end else if (match >= 0) begin
`ifdef VOICE_SUSTAIN_EN
            if (sus) m_sus[match] = 1;
            else     m_active[match] = 0;
`else
            if (sus || !sus) m_active[match] = 0;
`endif
        end
    endfunction

    task automatic applyStimulus(input bit on, input int note);
        int waited = 0;
        int low = 0;
        logic [6:0] n7;
        n7 = 7'(note);
        @(negedge clk);
        while (ev_bus.ev_ready_out !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("ready_before_event", 32'(ev_bus.ev_ready_out), 32'd1);
        ev_bus.ev_valid_in = 1'b1;
        ev_bus.ev_on_in    = on;
        ev_bus.ev_note_in  = n7;
        modelEvent(on, note, sustain);
        @(posedge clk);
        #1;
        ev_bus.ev_valid_in = 1'b0;
        while (ev_bus.ev_ready_out !== 1'b1 && low < 20) begin
            low++;
            @(posedge clk);
            #1;
        end
        obs_retrig = retrig;
        obs_steal  = steal;
        checkOutput("ready_low_cycles", 32'(low), 32'(NV + 1));
        checkOutput("retrig_pulse", 32'(retrig), 32'(exp_retrig));
        checkOutput("steal_pulse", 32'(steal), 32'(exp_steal));
        checkOutput("voice_active", 32'(active), 32'(modelActive()));
        checkOutput("voice_notes", 32'(notes), 32'(modelNotes()));
        @(posedge clk);
        #1;
        checkOutput("retrig_cleared", 32'(retrig), 32'd0);
        checkOutput("steal_cleared", 32'(steal), 32'd0);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        ev_bus.ev_valid_in = 1'b0;
        modelReset();
        #2;
        checkOutput("reset_active", 32'(active), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] seen;
        int pool [6];
        pool = '{0, 127, 60, 61, 62, 63};
        rst_n   = 1'b0;
        sustain = 1'b0;
        ev_bus.ev_valid_in = 1'b0;
        ev_bus.ev_on_in    = 1'b0;
        ev_bus.ev_note_in  = '0;
        modelReset();
        #22;
        rst_n = 1'b1;

        // Mid-scan reset loses the in-flight event and clears everything.
        applyStimulus(1, 10);
        applyStimulus(1, 20);
        @(negedge clk);
        ev_bus.ev_valid_in = 1'b1;
        ev_bus.ev_on_in    = 1'b1;
        ev_bus.ev_note_in  = 7'd33;
        @(posedge clk);
        #1;
        ev_bus.ev_valid_in = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("rst_ready", 32'(ev_bus.ev_ready_out), 32'd1);
        checkOutput("rst_active", 32'(active), 32'd0);
        checkOutput("rst_notes", 32'(notes), 32'd0);
        checkOutput("rst_retrig", 32'(retrig), 32'd0);
        checkOutput("rst_steal", 32'(steal), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            seen = seen | retrig | {3'b0, steal};
        end
        checkOutput("post_reset_no_pulse", 32'(seen), 32'd0);
        checkOutput("post_reset_ready", 32'(ev_bus.ev_ready_out), 32'd1);
        checkOutput("post_reset_active", 32'(active), 32'd0);

        // Directed chord, retrigger, fill and steal.
        applyStimulus(1, 60);
        checkOutput("first_voice0", 32'(obs_retrig), 32'd1);
        applyStimulus(1, 64);
        applyStimulus(1, 67);
        checkOutput("chord_active", 32'(active), 32'b0111);
        applyStimulus(1, 64);
        checkOutput("retrig_held_64", 32'(obs_retrig), 32'b0010);
        checkOutput("retrig_no_steal", 32'(obs_steal), 32'd0);
        applyStimulus(1, 71);
        applyStimulus(1, 72);
        checkOutput("steal_target", 32'(obs_retrig), 32'b0001);
        checkOutput("steal_flag", 32'(obs_steal), 32'd1);
        applyStimulus(0, 64);
        checkOutput("noteoff_64", 32'(active), 32'b1101);
        applyStimulus(1, 50);
        checkOutput("reuse_free", 32'(obs_retrig), 32'b0010);
        checkOutput("reuse_not_steal", 32'(obs_steal), 32'd0);
        applyStimulus(0, 99);
        checkOutput("noteoff_unheld", 32'(active), 32'b1111);

        // Saturation: three voices pinned at max age tie; lowest index is stolen.
        doReset();
        applyStimulus(1, 1);
        applyStimulus(1, 2);
        applyStimulus(1, 3);
        applyStimulus(1, 4);
        applyStimulus(1, 1);
        for (int k = 0; k < 20; k++) applyStimulus(1, 4);
        applyStimulus(1, 5);
        checkOutput("saturated_tie_steal", 32'(obs_retrig), 32'b0001);

        // Randomized events over a small note pool that includes 0 and 127.
        doReset();
        for (int k = 0; k < 60; k++) begin
            applyStimulus($urandom_range(0, 2) != 0, pool[$urandom_range(0, 5)]);
        end

        // Sustain pedal: note-off under sustain, then release the pedal.
        doReset();
        applyStimulus(1, 60);
        applyStimulus(1, 62);
        @(negedge clk);
        sustain = 1'b1;
        applyStimulus(0, 60);
        @(negedge clk);
        sustain = 1'b0;
`ifdef VOICE_SUSTAIN_EN
        checkOutput("sustain_held", 32'(active), 32'b0011);
        for (int i = 0; i < NV; i++) begin
            if (m_sus[i]) begin
                m_active[i] = 0;
                m_sus[i]    = 0;
            end
        end
        @(posedge clk);
        #1;
        checkOutput("flush_ready_low", 32'(ev_bus.ev_ready_out), 32'd0);
`else
        checkOutput("nosustain_freed", 32'(active), 32'b0010);
        @(posedge clk);
        #1;
`endif
        @(posedge clk);
        #1;
        checkOutput("sustain_release", 32'(active), 32'(modelActive()));
        checkOutput("sustain_release_abs", 32'(active), 32'b0010);
        applyStimulus(1, 70);
        checkOutput("after_release_free", 32'(obs_retrig), 32'b0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end
endmodule
